// File: rtl/psum_pkg.sv
// Shared types, widths and the requantisation helper for the partial-sum collector.
package psum_pkg;

  localparam int unsigned PSUM_LANES  = 4;
  localparam int unsigned PSUM_C_W    = 32;
  localparam int unsigned PSUM_OUT_W  = 8;
  localparam int unsigned PSUM_ADDR_W = 16;

  localparam logic signed [PSUM_C_W-1:0] Q_MAX = PSUM_C_W'((1 << (PSUM_OUT_W - 1)) - 1);
  localparam logic signed [PSUM_C_W-1:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PSUM_LANES*PSUM_OUT_W-1:0] data;
    logic [PSUM_ADDR_W-1:0]           addr;
  } out_entry_t;

  // Optional ReLU, arithmetic right shift, then saturate to the signed output range.
  function automatic logic [PSUM_OUT_W-1:0] requant(input logic signed [PSUM_C_W-1:0] sum,
                                                    input logic [4:0]                 shift,
                                                    input logic                       relu_en);
    logic signed [PSUM_C_W-1:0] v;
    logic [PSUM_OUT_W-1:0]      q;
    if (relu_en && sum[PSUM_C_W-1]) v = '0;
    else                            v = sum >>> shift;
    if (v > Q_MAX)      q = Q_MAX[PSUM_OUT_W-1:0];
    else if (v < Q_MIN) q = Q_MIN[PSUM_OUT_W-1:0];
    else                q = v[PSUM_OUT_W-1:0];
    return q;
  endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// Small synchronous FIFO of output entries; a pop frees a slot for a push in the same cycle.
module psum_out_fifo
  import psum_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  out_entry_t push_entry,
  input  logic       pop,
  output out_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  out_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Accumulates systolic-array partial sums across passes, requantises the final pass
// and streams addressed int8 words out through a small overflow-flagging FIFO.
module psum_collector
  import psum_pkg::*;
#(
  parameter int unsigned STREAM_WIDTH = PSUM_LANES,
  parameter int unsigned C_WIDTH      = PSUM_C_W,
  parameter int unsigned OUT_WIDTH    = PSUM_OUT_W,
  parameter int unsigned ADDR_WIDTH   = PSUM_ADDR_W,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [7:0]                        num_passes,
  input  logic [ADDR_WIDTH-1:0]             o_words,
  input  logic [4:0]                        shift,
  input  logic                              relu_en,
  input  logic [STREAM_WIDTH*C_WIDTH-1:0]   psum_in,
  input  logic                              psum_valid,
  output logic [STREAM_WIDTH*OUT_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]             out_addr,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow
);

  localparam int unsigned WORD_W = STREAM_WIDTH * C_WIDTH;
  localparam int unsigned BUF_AW = $clog2(DEPTH);

  state_t                state_q, state_d;
  logic [7:0]            cfg_passes;
  logic [ADDR_WIDTH-1:0] cfg_words;
  logic [4:0]            cfg_shift;
  logic                  cfg_relu;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [7:0]            pass_q;

  logic                  start_ok_c, accept_c, idx_last_c, pass_last_c;

  // Stage 1: accepted psum waiting for its buffer read; stage 2: registered sum.
  logic                  s1_valid, s1_first, s1_last;
  logic [WORD_W-1:0]     s1_psum;
  logic [ADDR_WIDTH-1:0] s1_idx;
  logic                  s2_valid;
  logic [ADDR_WIDTH-1:0] s2_idx;
  logic [WORD_W-1:0]     s2_sum;

  logic [WORD_W-1:0]     buf_mem [DEPTH];
  logic [WORD_W-1:0]     rd_q;
  logic [WORD_W-1:0]     prev_c, sum_c;
  logic                  fwd_c, push_c, drop_c, pop_c;

  out_entry_t            push_entry_c, fifo_head;
  logic                  fifo_full, fifo_empty;

  assign start_ok_c  = (state_q == IDLE) && start;
  assign accept_c    = (state_q == RUN) && psum_valid;
  assign idx_last_c  = (idx_q == cfg_words - ADDR_WIDTH'(1));
  assign pass_last_c = (pass_q == cfg_passes - 8'd1);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (num_passes == '0 || o_words == '0) ? DONE : RUN;
      end
      RUN: begin
        if (accept_c && idx_last_c && pass_last_c) state_d = FLUSH;
      end
      FLUSH: begin
        if (!s1_valid && fifo_empty) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, config, counters and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      cfg_passes <= '0;
      cfg_words  <= '0;
      cfg_shift  <= '0;
      cfg_relu   <= 1'b0;
      idx_q      <= '0;
      pass_q     <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN) || (state_d == FLUSH);
      done    <= (state_d == DONE);
      if (start_ok_c) begin
        cfg_passes <= num_passes;
        cfg_words  <= o_words;
        cfg_shift  <= shift;
        cfg_relu   <= relu_en;
        idx_q      <= '0;
        pass_q     <= '0;
        overflow   <= 1'b0;
      end else begin
        if (drop_c) overflow <= 1'b1;
        if (accept_c) begin
          if (idx_last_c) begin
            idx_q  <= '0;
            pass_q <= pass_q + 8'd1;
          end else begin
            idx_q  <= idx_q + ADDR_WIDTH'(1);
          end
        end
      end
    end
  end

  // Accumulation buffer: synchronous read of the incoming index, write-back of stage-1 sum
  always_ff @(posedge clk) begin
    if (s1_valid) buf_mem[s1_idx[BUF_AW-1:0]] <= sum_c;
    rd_q <= buf_mem[idx_q[BUF_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_psum  <= '0;
      s1_idx   <= '0;
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      s2_sum   <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_psum  <= psum_in;
        s1_idx   <= idx_q;
        s1_first <= (pass_q == '0);
        s1_last  <= pass_last_c;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_idx <= s1_idx;
        s2_sum <= sum_c;
      end
    end
  end

  // The read of a word written on the same edge returns stale data, so forward the last sum.
  assign fwd_c = s2_valid && (s2_idx == s1_idx);

  always_comb begin
    sum_c  = '0;
    prev_c = s1_first ? '0 : (fwd_c ? s2_sum : rd_q);
    for (int l = 0; l < int'(STREAM_WIDTH); l++) begin
      sum_c[l*C_WIDTH +: C_WIDTH] = s1_psum[l*C_WIDTH +: C_WIDTH] + prev_c[l*C_WIDTH +: C_WIDTH];
    end
  end

  always_comb begin
    push_entry_c      = '0;
    push_entry_c.addr = s1_idx;
    for (int l = 0; l < int'(STREAM_WIDTH); l++) begin
      push_entry_c.data[l*OUT_WIDTH +: OUT_WIDTH] =
        requant(sum_c[l*C_WIDTH +: C_WIDTH], cfg_shift, cfg_relu);
    end
  end

  assign push_c = s1_valid && s1_last;
  assign pop_c  = out_valid && out_ready;
  assign drop_c = push_c && fifo_full && !pop_c;

  psum_out_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_entry(push_entry_c),
    .pop       (pop_c),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head.data;
  assign out_addr  = fifo_head.addr;

endmodule

// File: doc/psum_collector.md
# psum_collector

Downstream stage of the systolic array: consumes the `valid_out`/`data_out` partial-sum stream and accumulates it across input-channel passes in an internal buffer. On the final pass it applies optional ReLU, an arithmetic right shift and int8 saturation. It then emits packed output words with addresses to the output memory over a valid/ready handshake. The array has no backpressure, so the block absorbs stalls in a small FIFO and flags overflow.

## Interface
Parameters:
- `STREAM_WIDTH`, 4: lanes per psum word (matches `stream_width`).
- `C_WIDTH`, 32: signed psum lane width (matches `C_WIDTH`).
- `OUT_WIDTH`, 8: signed output lane width.
- `ADDR_WIDTH`, 16: word index width.
- `DEPTH`, 1024: accumulation buffer entries, one psum word each.
- `FIFO_DEPTH`, 4: output FIFO entries, power of two.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that latches the config and begins a job.
- `num_passes`, in, 8: accumulation passes per job.
- `o_words`, in, ADDR_WIDTH: psum words per pass (≤ DEPTH).
- `shift`, in, 5: right-shift amount for requantisation.
- `relu_en`, in, 1: clamps negative sums to 0.
- `psum_in`, in, STREAM_WIDTH*C_WIDTH: array output; lane 0 in the LSBs.
- `psum_valid`, in, 1: `psum_in` is valid this cycle.
- `out_data`, out, STREAM_WIDTH*OUT_WIDTH: requantised word; lane 0 in the LSBs.
- `out_addr`, out, ADDR_WIDTH: word index, 0..o_words-1.
- `out_valid`, out, 1; `out_ready`, in, 1: output handshake.
- `busy`, out, 1: job in progress.
- `done`, out, 1: one-cycle pulse at the end of a job.
- `overflow`, out, 1: sticky; a final-pass word was dropped.

## Operation
- States:
  - IDLE → RUN on `start`. If `num_passes`=0 or `o_words`=0, the block instead goes straight to DONE.
  - RUN → FLUSH after word `o_words`-1 of pass `num_passes`-1 has been accepted.
  - FLUSH → DONE when the pipeline and FIFO are empty.
  - DONE → IDLE unconditionally; `done`=1 for that one cycle.
- `busy`=1 in RUN and FLUSH.
- `start` outside IDLE is ignored. `psum_valid` outside RUN is ignored (not counted).
- Counters `idx` (0..o_words-1) and `pass` (0..num_passes-1). Each accepted word advances `idx`; when `idx` wraps to 0, `pass` increments.
- Accumulation, per lane:
  - `sum = psum + (pass==0 ? 0 : buf[idx])`, wrapping modulo 2^C_WIDTH.
  - `sum` is written back to `buf[idx]`.
  - Pass 0 overwrites, so buffer contents after reset are never relied on.
- Read-after-write hazard: when the previous cycle wrote the same `idx` (only possible when `o_words`=1), the in-flight sum is forwarded instead of reading the buffer.
- Requantisation on the final pass, per lane:
  - If `relu_en` and `sum`<0, then v=0; otherwise v = `sum` >>> `shift` (arithmetic, truncating).
  - v saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - `{data, idx}` is pushed into the FIFO.
- FIFO full on push: the word is dropped and `overflow` is set. `overflow` clears only on the next accepted `start` or on reset.
- A word transfers when `out_valid && out_ready`. Simultaneous push and pop on a full FIFO succeeds without overflow.
- Reset mid-job forces IDLE, clears the counters and FIFO, and drives all outputs low. The next `start` behaves normally.

## Timing
- Reset values: `out_valid`, `busy`, `done` and `overflow` are 0; `out_data` and `out_addr` are 0.
- Pipeline, for a psum accepted at cycle t:
  - Buffer read at t.
  - Sum registered and written back at t+1.
  - Quantised word pushed at t+2.
  - `out_valid` at t+2 if the FIFO was empty and `out_ready` was irrelevant.
- Full throughput: one psum per cycle, back-to-back, including across pass boundaries.
- `out_data` and `out_addr` stay stable while `out_valid && !out_ready`.
- Config is latched on `start`. Changes to the config inputs mid-job have no effect.
- For the last word accepted at t, `done` is asserted no earlier than t+3, and only after the last FIFO pop.

## Structure
- Package `psum_pkg`:
  - Lane-width constants.
  - `state_t` enum {IDLE, RUN, FLUSH, DONE}.
  - Function `requant(sum, shift, relu_en)` returning an OUT_WIDTH-bit value.
  - Packed `out_entry_t` {data, addr}.
- Accumulation buffer: an inferred single-clock simple-dual-port RAM, written inline.
- One sub-module, `psum_out_fifo`: a synchronous FIFO of `out_entry_t` with full/empty and simultaneous push/pop.

## Test plan
- `num_passes`=1, `o_words`=4, `shift`=0, lanes {1,2,3,4}, `out_ready`=1 → four words at addresses 0..3 with lanes {1,2,3,4}; `done` once.
- `num_passes`=3, `o_words`=2, each psum lane=10, `shift`=1 → outputs only after pass 3, lanes = 15; addresses 0,1.
- Saturation/ReLU: lanes {1000, -1000, -5, 255}, `shift`=0 → {127, -128, -5, 127}. With `relu_en`=1 → {127, 0, 0, 127}.
- `o_words`=1, `num_passes`=4, back-to-back valid lanes=7 → forwarding exercised; single output lane 28.
- `out_ready`=0 with 6 final-pass words, FIFO_DEPTH=4 → 4 held, 2 dropped, `overflow`=1. Releasing ready yields addresses 0..3, then `done`.
- Reset asserted mid-RUN, then a fresh job (`num_passes`=1, `o_words`=2) → clean outputs at addresses 0,1 and `overflow`=0.
